spi_master: RTL and testbench

SPI master that runs one 8-bit, MSB-first, mode-0 (CPOL=0, CPHA=0) full-duplex frame per start request. It drives SS, SCK and MOSI, samples MISO, and returns the received byte with a one-cycle done pulse. It is the initiator end for the SPI_slave block and sits on the system-clock side, between a local controller (register file/FSM) and the SPI pins. Its timing gives SPI_slave's 2-flop synchronisers and edge detectors enough clk cycles to track every pin transition.

---
 rtl/spi_master.sv | 164 ++++++++++++++++
 tb/tb_spi_master.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master: one 8-bit, MSB-first, mode-0 full-duplex frame per start request.
// SS/SCK/MOSI and all status outputs come straight from flops; MISO is
// double-flop synchronised before it is shifted into the receive register.
module spi_master #(
  parameter int HALF_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       MISO,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       SS,
  output logic       SCK,
  output logic       MOSI
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_TRAIL,
    S_GAP
  } state_t;

  // Divider terminal count: every timed state lasts HALF_PERIOD cycles.
  localparam logic [7:0] DIV_LAST = 8'(HALF_PERIOD - 1);

  state_t     r_state, w_state_next;
  logic [7:0] r_div, w_div_next;
  logic [2:0] r_bit, w_bit_next;
  logic [7:0] r_tx, w_tx_next;
  logic [7:0] r_rx, w_rx_next;
  logic [7:0] r_rx_data, w_rx_data_next;
  logic       r_ss, w_ss_next;
  logic       r_sck, w_sck_next;
  logic       r_busy, w_busy_next;
  logic       r_done, w_done_next;
  logic       r_miso_meta, r_miso_sync;
  logic       w_div_end;

  assign w_div_end = (r_div == DIV_LAST);

  // MOSI is the MSB of the tx shift register; it is cleared on entering GAP.
  assign SS      = r_ss;
  assign SCK     = r_sck;
  assign MOSI    = r_tx[7];
  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;

  // Two-flop synchroniser for the asynchronous MISO pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
    end else begin
      r_miso_meta <= MISO;
      r_miso_sync <= r_miso_meta;
    end
  end

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_div     <= 8'd0;
      r_bit     <= 3'd0;
      r_tx      <= 8'd0;
      r_rx      <= 8'd0;
      r_rx_data <= 8'd0;
      r_ss      <= 1'b1;
      r_sck     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_div     <= w_div_next;
      r_bit     <= w_bit_next;
      r_tx      <= w_tx_next;
      r_rx      <= w_rx_next;
      r_rx_data <= w_rx_data_next;
      r_ss      <= w_ss_next;
      r_sck     <= w_sck_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  // Next-state and next-output logic; outputs change only on state entry.
  always_comb begin
    w_state_next   = r_state;
    w_div_next     = r_div + 8'd1;
    w_bit_next     = r_bit;
    w_tx_next      = r_tx;
    w_rx_next      = r_rx;
    w_rx_data_next = r_rx_data;
    w_ss_next      = r_ss;
    w_sck_next     = r_sck;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_div_next = 8'd0;
        if (start) begin
          w_state_next = S_LEAD;
          w_tx_next    = tx_data;
          w_bit_next   = 3'd0;
          w_ss_next    = 1'b0;
          w_busy_next  = 1'b1;
        end
      end
      S_LEAD, S_LOW: begin
        if (w_div_end) begin
          // Rising edge: sample the synchronised MISO into the rx LSB.
          w_state_next = S_HIGH;
          w_div_next   = 8'd0;
          w_sck_next   = 1'b1;
          w_rx_next    = {r_rx[6:0], r_miso_sync};
        end
      end
      S_HIGH: begin
        if (w_div_end) begin
          w_div_next = 8'd0;
          w_sck_next = 1'b0;
          if (r_bit == 3'd7) begin
            // Last falling edge: MOSI keeps bit 0 through TRAIL.
            w_state_next = S_TRAIL;
          end else begin
            w_state_next = S_LOW;
            w_bit_next   = r_bit + 3'd1;
            w_tx_next    = {r_tx[6:0], 1'b0};
          end
        end
      end
      S_TRAIL: begin
        if (w_div_end) begin
          w_state_next   = S_GAP;
          w_div_next     = 8'd0;
          w_ss_next      = 1'b1;
          w_tx_next      = 8'd0;
          w_done_next    = 1'b1;
          w_rx_data_next = r_rx;
        end
      end
      S_GAP: begin
        if (w_div_end) begin
          w_state_next = S_IDLE;
          w_div_next   = 8'd0;
          w_busy_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_div_next   = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural SPI slave answers on MISO and collects
// MOSI, and every cycle of each frame is compared against pin values derived
// from the frame timing formulas (cycle index arithmetic only).
module tb_spi_master;

  localparam int H = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic       MISO;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       SS;
  logic       SCK;
  logic       MOSI;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_rx;

  // Behavioural slave state
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] slave_rx   = 8'h00;
  logic [7:0] sl_sh      = 8'h00;
  int         sl_dly     = 0;
  logic       prev_ss    = 1'b1;
  logic       prev_sck   = 1'b0;

  spi_master #(.HALF_PERIOD(H)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .MISO    (MISO),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .SS      (SS),
    .SCK     (SCK),
    .MOSI    (MOSI)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {SS,SCK,MOSI,busy,done} in frame cycle c (cycle 0 = start accepted).
  function automatic logic [4:0] exp_pins(input int c, input logic [7:0] tx);
    logic e_ss, e_sck, e_mosi, e_busy, e_done;
    int   j;
    e_ss  = !(c >= 1 && c < 1 + 17*H);
    e_sck = 1'b0;
    for (int k = 0; k < 8; k++)
      if (c >= 1 + H*(2*k+1) && c < 1 + H*(2*k+2)) e_sck = 1'b1;
    if (e_ss) begin
      e_mosi = 1'b0;
    end else begin
      j = (c - 1) / (2*H);
      if (j > 7) j = 7;
      e_mosi = tx[7-j];
    end
    e_busy = (c >= 1 && c <= 18*H);
    e_done = (c == 1 + 17*H);
    return {e_ss, e_sck, e_mosi, e_busy, e_done};
  endfunction

  // Slave: loads its byte on SS fall, presents the next bit 3 cycles after
  // SS fall / each SCK fall, and captures MOSI on each SCK rise.
  always @(negedge clk) begin
    if (SS) begin
      sl_dly = 0;
      MISO = 1'($urandom_range(0, 1));
    end else begin
      if (prev_ss) begin
        sl_sh    = slave_byte;
        slave_rx = 8'h00;
        sl_dly   = 3;
      end else if (prev_sck && !SCK) begin
        sl_dly = 3;
      end
      if (!prev_sck && SCK) slave_rx = {slave_rx[6:0], MOSI};
      if (sl_dly > 0) begin
        sl_dly--;
        if (sl_dly == 0) begin
          MISO  = sl_sh[7];
          sl_sh = {sl_sh[6:0], 1'b0};
        end
      end
    end
    prev_ss  = SS;
    prev_sck = SCK;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_eq("idle", {SS, SCK, MOSI, busy, done, rx_data}, {5'b10000, exp_rx});
      start   = 1'b0;
      tx_data = 8'($urandom);
    end
  endtask

  // Called at a negedge; that cycle is frame cycle 0.
  task automatic run_frame(input logic [7:0] tx, input logic [7:0] sl, input int abort_at);
    slave_byte = sl;
    start      = 1'b1;
    tx_data    = tx;
    for (int c = 1; c <= 1 + 18*H; c++) begin
      @(negedge clk);
      if (c == 1 + 17*H) exp_rx = sl;
      check_eq("pins", {SS, SCK, MOSI, busy, done, rx_data}, {exp_pins(c, tx), exp_rx});
      if (c == 1 + 17*H) check_eq("slave_rx", {24'd0, slave_rx}, {24'd0, tx});
      start   = (c == 5) || (c == 100) || (c <= 18*H && $urandom_range(0, 3) == 0);
      tx_data = 8'($urandom);
      if (c == abort_at) begin
        rst   = 1'b0;
        start = 1'b0;
        #1;
        exp_rx = 8'h00;
        check_eq("abort", {SS, SCK, MOSI, busy, done, rx_data}, {5'b10000, 8'h00});
        repeat (3) begin
          @(negedge clk);
          check_eq("in_reset", {SS, SCK, MOSI, busy, done, rx_data}, {5'b10000, 8'h00});
        end
        rst = 1'b1;
        $display("frame tx=%02h slave=%02h aborted at cycle %0d", tx, sl, abort_at);
        return;
      end
    end
    $display("frame tx=%02h slave=%02h rx_data=%02h slave_rx=%02h", tx, sl, rx_data, slave_rx);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    tx_data = 8'h00;
    exp_rx  = 8'h00;
    #1 rst  = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("reset", {SS, SCK, MOSI, busy, done, rx_data}, {5'b10000, 8'h00});
      start   = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
    end
    start = 1'b0;
    rst   = 1'b1;
    idle(20);

    // Directed loopback frame
    run_frame(8'hA5, 8'h3C, 0);
    idle(10);

    // Random frames, some back-to-back
    for (int i = 0; i < 4; i++) begin
      run_frame(8'($urandom), 8'($urandom), 0);
      idle($urandom_range(0, 4));
    end

    // Back-to-back with start held at the busy-low cycle
    run_frame(8'hFF, 8'h81, 0);
    run_frame(8'h00, 8'h7E, 0);
    idle(5);

    // Reset mid-frame, then a clean frame
    run_frame(8'($urandom), 8'($urandom), 60);
    idle(10);
    run_frame(8'h5A, 8'hC3, 0);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
